// File: rtl/lcd_write_scheduler.sv
// Write scheduler in front of the LCD driver: queues decoded characters, tracks the
// cursor, and interleaves user clears and line-wrap commands with character writes.
module lcd_write_scheduler #(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          COLS        = 16,
    parameter logic [7:0]  LINE2_ADDR  = 8'hC0,
    parameter logic [7:0]  CLEAR_CMD   = 8'h01,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_char_valid,
    input  logic [7:0]              i_char_data,
    input  logic                    i_clr_req,
    input  logic                    i_drv_busy,
    output logic                    o_drv_write,
    output logic [7:0]              o_drv_data,
    output logic                    o_drv_rs,
    output logic                    o_fifo_full,
    output logic                    o_dropped,
    output logic                    o_err,
    output logic [$clog2(COLS)-1:0] o_cursor_col,
    output logic                    o_cursor_row,
    output logic                    o_idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(COLS);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_ACK  = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    localparam logic [1:0] K_CHAR  = 2'd0;
    localparam logic [1:0] K_WRAP  = 2'd1;
    localparam logic [1:0] K_CLEAR = 2'd2;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_dropped;

    logic [1:0]    r_state;
    logic [1:0]    r_kind;
    logic          r_drv_write;
    logic [7:0]    r_drv_data;
    logic          r_drv_rs;
    logic [TW-1:0] r_timer;
    logic          r_err;
    logic [CW-1:0] r_col;
    logic          r_row;
    logic          r_clr_pending;
    logic          r_wrap_pending;

    logic w_empty, w_full, w_start, w_sel_clr, w_sel_wrap, w_pop, w_flush;
    logic w_push_req, w_push;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_start    = (r_state == S_IDLE) && i_en && !i_drv_busy &&
                        (r_clr_pending || r_wrap_pending || !w_empty);
    assign w_sel_clr  = w_start && r_clr_pending;
    assign w_sel_wrap = w_start && !r_clr_pending && r_wrap_pending;
    assign w_pop      = w_start && !r_clr_pending && !r_wrap_pending;
    assign w_flush    = w_sel_clr;
    assign w_push_req = i_char_valid && i_en;
    // A flush frees every slot, so a character arriving with the clear is still kept.
    assign w_push     = w_push_req && (!w_full || w_pop || w_flush);

    // NOTE: the storage array has no reset; the count and pointers alone say which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_char_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= w_push_req && !w_push;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= w_push ? (AW+1)'(1) : '0;
            end else begin
                if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_kind         <= K_CHAR;
            r_drv_write    <= 1'b0;
            r_drv_data     <= '0;
            r_drv_rs       <= 1'b0;
            r_timer        <= '0;
            r_err          <= 1'b0;
            r_col          <= '0;
            r_row          <= 1'b0;
            r_clr_pending  <= 1'b1;
            r_wrap_pending <= 1'b0;
        end else begin
            r_drv_write <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_ISSUE;
                        r_drv_write <= 1'b1;
                        r_drv_rs    <= 1'b0;
                        if (w_sel_clr) begin
                            r_kind         <= K_CLEAR;
                            r_drv_data     <= CLEAR_CMD;
                            r_wrap_pending <= 1'b0;
                        end else if (w_sel_wrap) begin
                            r_kind         <= K_WRAP;
                            r_drv_data     <= r_row ? CLEAR_CMD : LINE2_ADDR;
                            r_wrap_pending <= 1'b0;
                        end else begin
                            r_kind     <= K_CHAR;
                            r_drv_data <= r_mem[r_rd_ptr];
                            r_drv_rs   <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT_ACK;
                    r_timer <= '0;
                end
                S_WAIT_ACK: begin
                    if (i_drv_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_drv_busy) begin
                        r_state <= S_IDLE;
                        case (r_kind)
                            K_CHAR: begin
                                if (r_col == CW'(COLS - 1)) begin
                                    r_col          <= '0;
                                    r_wrap_pending <= 1'b1;
                                end else begin
                                    r_col <= r_col + 1'b1;
                                end
                            end
                            K_WRAP:  r_row <= ~r_row;
                            default: begin
                                r_col <= '0;
                                r_row <= 1'b0;
                            end
                        endcase
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // A new request in the same cycle as a clear issue must survive it.
            if (i_clr_req && i_en)  r_clr_pending <= 1'b1;
            else if (w_sel_clr)     r_clr_pending <= 1'b0;
        end
    end

    assign o_drv_write  = r_drv_write;
    assign o_drv_data   = r_drv_data;
    assign o_drv_rs     = r_drv_rs;
    assign o_fifo_full  = w_full;
    assign o_dropped    = r_dropped;
    assign o_err        = r_err;
    assign o_cursor_col = r_col;
    assign o_cursor_row = r_row;
    assign o_idle       = (r_state == S_IDLE) && w_empty && !r_clr_pending && !r_wrap_pending;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Directed bench for lcd_write_scheduler with a small behavioural model of the LCD driver's busy line.
module tb_lcd_write_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       char_valid;
    logic [7:0] char_data;
    logic       clr_req;
    logic       busy;
    logic       drv_write;
    logic [7:0] drv_data;
    logic       drv_rs;
    logic       fifo_full;
    logic       dropped;
    logic       err;
    logic [3:0] cursor_col;
    logic       cursor_row;
    logic       idle;

    int n_assert = 0;
    int n_fail   = 0;

    // Driver model controls: stall holds busy high, dead ignores strobes entirely.
    logic stall = 1'b0;
    logic dead  = 1'b0;

    lcd_write_scheduler dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_char_valid (char_valid),
        .i_char_data  (char_data),
        .i_clr_req    (clr_req),
        .i_drv_busy   (busy),
        .o_drv_write  (drv_write),
        .o_drv_data   (drv_data),
        .o_drv_rs     (drv_rs),
        .o_fifo_full  (fifo_full),
        .o_dropped    (dropped),
        .o_err        (err),
        .o_cursor_col (cursor_col),
        .o_cursor_row (cursor_row),
        .o_idle       (idle)
    );

    always #5 clk = ~clk;

    // Busy rises 3 cycles after each strobe and stays high for 10 cycles (longer while stalled).
    initial begin
        int dly;
        int bcnt;
        busy = 1'b0;
        dly  = 0;
        bcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                busy = 1'b0;
                dly  = 0;
                bcnt = 0;
            end else begin
                if (dly != 0) begin
                    dly--;
                    if (dly == 0) begin
                        busy = 1'b1;
                        bcnt = 10;
                    end
                end else if (bcnt != 0) begin
                    bcnt--;
                    if (bcnt == 0 && !stall) busy = 1'b0;
                end else if (busy && !stall) begin
                    busy = 1'b0;
                end
                if (drv_write && !dead) dly = 3;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        char_valid = 1'b1;
        char_data  = d;
        tick();
        char_valid = 1'b0;
    endtask

    task automatic wait_strobe(input string tag, input logic [7:0] exp_d, input logic exp_rs);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!drv_write && n < 400);
        check({tag, "_strobe"}, 32'(drv_write), 32'd1);
        check({tag, "_data"}, 32'(drv_data), 32'(exp_d));
        check({tag, "_rs"}, 32'(drv_rs), 32'(exp_rs));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!idle && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    initial begin
        int cnt;
        rst        = 1'b1;
        en         = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        clr_req    = 1'b0;
        repeat (3) tick();

        check("rst_write", 32'(drv_write), 32'd0);
        check("rst_data", 32'(drv_data), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_col", 32'(cursor_col), 32'd0);
        check("rst_idle", 32'(idle), 32'd0);

        // First transaction after reset is the clear command.
        rst = 1'b0;
        wait_strobe("boot", 8'h01, 1'b0);
        wait_idle("boot");
        check("boot_col", 32'(cursor_col), 32'd0);
        check("boot_row", 32'(cursor_row), 32'd0);

        // Push at edge N; strobe appears two cycles later.
        push(8'h41);
        check("lat_n1", 32'(drv_write), 32'd0);
        tick();
        check("lat_n2", 32'(drv_write), 32'd1);
        check("lat_data", 32'(drv_data), 32'h41);
        check("lat_rs", 32'(drv_rs), 32'd1);
        wait_idle("lat");
        check("lat_col", 32'(cursor_col), 32'd1);

        // Clear from idle, then fill a full line and one more.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wait_strobe("clr0", 8'h01, 1'b0);
        wait_idle("clr0");
        check("clr0_col", 32'(cursor_col), 32'd0);

        for (int i = 0; i < 17; i++) begin
            push(8'h30 + 8'(i));
            wait_strobe($sformatf("line_%0d", i), 8'h30 + 8'(i), 1'b1);
            if (i == 15) wait_strobe("wrap", 8'hC0, 1'b0);
            wait_idle($sformatf("line_%0d", i));
            if (i == 15) begin
                check("wrap_row", 32'(cursor_row), 32'd1);
                check("wrap_col", 32'(cursor_col), 32'd0);
            end
        end
        check("line17_col", 32'(cursor_col), 32'd1);
        check("line17_row", 32'(cursor_row), 32'd1);

        // Stalled driver: one write in flight, four queued, two dropped.
        stall = 1'b1;
        push(8'h50);
        wait_strobe("stall_first", 8'h50, 1'b1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            push(8'h51 + 8'(i));
            cnt += int'(dropped);
        end
        check("stall_full", 32'(fifo_full), 32'd1);
        tick();
        cnt += int'(dropped);
        tick();
        cnt += int'(dropped);
        check("stall_drops", 32'(cnt), 32'd2);
        stall = 1'b0;
        for (int i = 0; i < 4; i++)
            wait_strobe($sformatf("drain_%0d", i), 8'h51 + 8'(i), 1'b1);
        wait_idle("drain");
        check("drain_col", 32'(cursor_col), 32'd6);
        check("drain_full", 32'(fifo_full), 32'd0);

        // Driver never acknowledges: ERR after ACK_TIMEOUT cycles in WAIT_ACK.
        dead = 1'b1;
        push(8'h70);
        wait_strobe("to", 8'h70, 1'b1);
        cnt = 0;
        for (int i = 0; i < 255; i++) begin
            tick();
            cnt += int'(err);
        end
        check("to_early_err", 32'(cnt), 32'd0);
        tick();
        check("to_err", 32'(err), 32'd1);
        check("to_idle", 32'(idle), 32'd1);
        tick();
        check("to_err_pulse", 32'(err), 32'd0);
        check("to_col", 32'(cursor_col), 32'd6);
        check("to_row", 32'(cursor_row), 32'd1);
        dead = 1'b0;

        // Clear requested with three characters queued behind an in-flight write.
        push(8'h60);
        wait_strobe("cq_first", 8'h60, 1'b1);
        push(8'h61);
        push(8'h62);
        push(8'h63);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wait_strobe("cq_clear", 8'h01, 1'b0);
        wait_idle("cq");
        check("cq_col", 32'(cursor_col), 32'd0);
        check("cq_row", 32'(cursor_row), 32'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cnt += int'(drv_write);
        end
        check("cq_no_more", 32'(cnt), 32'd0);

        // Enable low: pushes and clear requests are ignored.
        en = 1'b0;
        push(8'h72);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt += int'(drv_write);
        end
        check("en_no_strobe", 32'(cnt), 32'd0);
        check("en_idle", 32'(idle), 32'd1);
        en = 1'b1;

        // Reset during the strobe cycle abandons the write immediately.
        push(8'h71);
        wait_strobe("rmid", 8'h71, 1'b1);
        rst = 1'b1;
        #1;
        check("rmid_write", 32'(drv_write), 32'd0);
        check("rmid_data", 32'(drv_data), 32'd0);
        check("rmid_idle", 32'(idle), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        wait_strobe("rmid_boot", 8'h01, 1'b0);
        wait_idle("rmid_boot");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_write_scheduler.md
Name: lcd_write_scheduler

Overview:
- Sequences every write into the LCD driver FSM: buffers decoded Morse characters, tracks the cursor, and inserts line-wrap and clear commands.
- Arbitrates between a user clear request, internally generated wrap commands and the character FIFO.
- Sits between the Morse-to-character decoder (one-cycle send pulse plus 8-bit code) and the LCD driver's write/busy handshake.

Parameters:
- FIFO_DEPTH, 4, character FIFO entries; power of 2, minimum 2.
- COLS, 16, characters per display line.
- LINE2_ADDR, 8'hC0, set-DDRAM-address command for the start of line 2.
- CLEAR_CMD, 8'h01, clear-display/home command.
- ACK_TIMEOUT, 255, cycles to wait for DRV_BUSY to rise after a write pulse.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  enable; when low, no new transaction starts and CHAR_VALID/CLR_REQ are ignored.
- CHAR_VALID  in  1  one-cycle pulse, CHAR_DATA valid.
- CHAR_DATA  in  8  character code.
- CLR_REQ  in  1  one-cycle pulse requesting a display clear.
- DRV_BUSY  in  1  driver busy; high while a write is in progress.
- DRV_WRITE  out  1  one-cycle write strobe to the driver.
- DRV_DATA  out  8  byte to write.
- DRV_RS  out  1  1 = data (character), 0 = command.
- FIFO_FULL  out  1  FIFO holds FIFO_DEPTH entries.
- DROPPED  out  1  one-cycle pulse: a character was lost because the FIFO was full.
- ERR  out  1  one-cycle pulse: ACK timeout expired.
- CURSOR_COL  out  $clog2(COLS)  current column, 0..COLS-1.
- CURSOR_ROW  out  1  current row, 0..1.
- IDLE_O  out  1  high when in IDLE with no pending work.

Behaviour:

Reset:
- All outputs 0, FIFO empty, state IDLE, cursor (0,0).
- clr_pending resets to 1, so the first transaction after reset is always CLEAR_CMD.

FIFO:
- Push when CHAR_VALID && EN && (!full || pop in the same cycle).
- Push while full with no pop: character discarded and DROPPED pulses in the next cycle.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Request latching:
- CLR_REQ && EN sets clr_pending.
- clr_pending clears when the clear command is issued.

States:
- IDLE → ISSUE when EN && !DRV_BUSY && work pending.
  - Selection priority: clr_pending > wrap_pending > FIFO not empty.
  - The selected byte and RS are registered into DRV_DATA/DRV_RS on this transition.
- ISSUE: DRV_WRITE = 1 for exactly this one cycle; → WAIT_ACK.
- WAIT_ACK:
  - DRV_BUSY = 1 → WAIT_DONE.
  - Timeout counter reaches ACK_TIMEOUT → IDLE and ERR pulses.
  - A timed-out transaction is not retried, and the cursor does not advance.
- WAIT_DONE: DRV_BUSY = 0 → IDLE; the cursor update is applied on this transition.

Outputs and latency:
- DRV_DATA and DRV_RS stay stable from ISSUE through the exit from WAIT_DONE.
- A character pushed at edge N with the FIFO empty, IDLE state and BUSY low gives DRV_WRITE high during cycle N+2.

Cursor update (at WAIT_DONE exit):
- Character: col+1. If the result equals COLS, col = 0 and wrap_pending = 1.
- Wrap command:
  - row 0 → issue LINE2_ADDR (RS = 0); row becomes 1.
  - row 1 → issue CLEAR_CMD (RS = 0); row becomes 0.
  - wrap_pending clears.
- Clear command: cursor (0,0); FIFO is flushed and wrap_pending cleared at the moment of issue. Characters pushed after issue are kept.

Boundary rules:
- EN low mid-transaction: the in-flight transaction completes normally; the FSM then holds in IDLE.
- CLR_REQ while busy: latched; served next, ahead of any queued character.
- RST mid-transaction: immediate return to reset state. DRV_WRITE drops, and the outstanding driver write is abandoned.
- IDLE_O = (state == IDLE) && FIFO empty && !clr_pending && !wrap_pending.

Test Plan:
- Release RST with DRV_BUSY modelled as high 3 cycles after each strobe for 10 cycles → first strobe DRV_DATA=8'h01, DRV_RS=0; cursor (0,0); IDLE_O=1 afterwards.
- Push 8'h41 once idle → DRV_WRITE in cycle N+2 with DRV_DATA=8'h41, DRV_RS=1; after BUSY falls, CURSOR_COL=1.
- Push 17 characters → after the 16th, the strobe carries 8'hC0 with RS=0 and row becomes 1; the 17th character is written with CURSOR_COL=1 afterwards.
- With the driver stalled busy, push 6 characters (depth 4, one already in flight) → DROPPED pulses for the excess pushes, FIFO_FULL=1, and the remaining 4 are written in order once the stall releases.
- Assert CLR_REQ while 3 characters are queued mid-transaction → the next strobe is 8'h01/RS=0, the queued characters are never written, and the cursor is (0,0).
- Hold DRV_BUSY low forever after a strobe → ERR pulses exactly ACK_TIMEOUT cycles into WAIT_ACK, the FSM returns to IDLE, and the cursor is unchanged.
